// File: rtl/bu2020_fetch.sv
// Instruction fetch unit: single-outstanding memory requester feeding a 2-entry
// in-order instruction FIFO, with redirect flush and in-flight response discard.
module bu2020_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_STEP  = 16'h0004
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic        inst_valid,
    output logic [15:0] inst_data,
    output logic [15:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc
);

    typedef enum logic {RUN, DISCARD} state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic        req_q, req_d;
    logic [15:0] addr_q, addr_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        rd_ptr, wr_ptr;
    logic [15:0] fifo_data [2];
    logic [15:0] fifo_pc   [2];
    logic        fire, push, pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
            cnt_q   <= 2'd0;
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            if (redirect_valid) begin
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
            end else begin
                if (push) wr_ptr <= ~wr_ptr;
                if (pop)  rd_ptr <= ~rd_ptr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= imem_rdata;
            fifo_pc[wr_ptr]   <= addr_q;
        end
    end

    always_comb begin
        fire    = req_q & imem_ack;
        push    = fire & (state_q == RUN) & ~redirect_valid;
        pop     = (cnt_q != 2'd0) & inst_ready & ~redirect_valid;
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            RUN: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                    // The in-flight response still has to come back; swallow it.
                    if (req_q && !imem_ack) state_d = DISCARD;
                end else if (push) begin
                    pc_d = pc_q + PC_STEP;
                end
            end
            DISCARD: begin
                if (redirect_valid) pc_d = redirect_pc;
                if (fire) state_d = RUN;
            end
            default: state_d = RUN;
        endcase

        if (redirect_valid) cnt_d = 2'd0;
        else                cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};

        // Outstanding request is frozen until acked; otherwise issue while room remains.
        if (req_q && !imem_ack) begin
            req_d  = 1'b1;
            addr_d = addr_q;
        end else begin
            req_d  = (cnt_d < 2'd2);
            addr_d = req_d ? pc_d : addr_q;
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = addr_q;
    assign inst_valid = (cnt_q != 2'd0);
    assign inst_data  = fifo_data[rd_ptr];
    assign inst_pc    = fifo_pc[rd_ptr];

endmodule

// File: tb/tb_bu2020_fetch.sv
// Directed bench for bu2020_fetch; memory returns addr ^ 16'h5A00 as the instruction.
module tb_bu2020_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req, imem_ack, inst_valid, inst_ready, redirect_valid;
    logic [15:0] imem_addr, imem_rdata, inst_data, inst_pc, redirect_pc;
    logic        ack_auto, ack_man;

    logic        w_req, w_valid;
    logic [15:0] w_addr, w_data, w_pc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign imem_ack   = ack_auto ? imem_req : ack_man;
    assign imem_rdata = imem_addr ^ 16'h5A00;

    bu2020_fetch dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
        .inst_ready(inst_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    bu2020_fetch #(.RESET_PC(16'hFFFC)) u_wrap (
        .clk(clk), .rst(rst),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(w_req), .imem_rdata(w_addr ^ 16'h5A00),
        .inst_valid(w_valid), .inst_data(w_data), .inst_pc(w_pc),
        .inst_ready(1'b1),
        .redirect_valid(1'b0), .redirect_pc(16'h0000)
    );

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        ack_auto = 1'b1; ack_man = 1'b0; inst_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 16'h1234;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
        checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h expected 0000", imem_addr); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", inst_valid); end
        redirect_valid = 1'b0;
    endtask

    task automatic test_stream();
        ack_auto = 1'b1; inst_ready = 1'b1;
        do_reset();
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("FAIL stream_first_req: got %b/%h expected 1/0000", imem_req, imem_addr); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL stream_first_valid: got %b expected 0", inst_valid); end
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checks++; if (imem_addr !== 16'(4*k)) begin errors++; $display("FAIL stream_addr[%0d]: got %h expected %h", k, imem_addr, 16'(4*k)); end
            checks++; if (inst_valid !== 1'b1 || inst_pc !== 16'(4*(k-1))) begin errors++; $display("FAIL stream_pc[%0d]: got %b/%h expected 1/%h", k, inst_valid, inst_pc, 16'(4*(k-1))); end
            checks++; if (inst_data !== (16'(4*(k-1)) ^ 16'h5A00)) begin errors++; $display("FAIL stream_data[%0d]: got %h expected %h", k, inst_data, 16'(4*(k-1)) ^ 16'h5A00); end
        end
    endtask

    task automatic test_stall();
        int acks;
        logic [15:0] exp_pc;
        ack_auto = 1'b1; inst_ready = 1'b0;
        do_reset();
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (imem_req && imem_ack) acks++;
        end
        checks++; if (acks != 2) begin errors++; $display("FAIL stall_acks: got %0d expected 2", acks); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req: got %b expected 0", imem_req); end
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 16'h0000) begin errors++; $display("FAIL stall_head: got %b/%h expected 1/0000", inst_valid, inst_pc); end
        inst_ready = 1'b1;
        exp_pc = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            checks++; if (inst_valid !== 1'b1 || inst_pc !== exp_pc) begin errors++; $display("FAIL stall_drain[%0d]: got %b/%h expected 1/%h", i, inst_valid, inst_pc, exp_pc); end
            exp_pc = exp_pc + 16'h0004;
            @(negedge clk);
        end
    endtask

    task automatic test_redirect_wait();
        ack_auto = 1'b0; ack_man = 1'b0; inst_ready = 1'b1;
        do_reset();
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("FAIL rw_req: got %b/%h expected 1/0000", imem_req, imem_addr); end
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 16'h0100;
        @(negedge clk);
        redirect_valid = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("FAIL rw_hold: got %b/%h expected 1/0000", imem_req, imem_addr); end
        @(negedge clk);
        ack_man = 1'b1;
        @(negedge clk);
        ack_man = 1'b0;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rw_dropped: got %b expected 0", inst_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0100) begin errors++; $display("FAIL rw_newaddr: got %b/%h expected 1/0100", imem_req, imem_addr); end
        ack_man = 1'b1;
        @(negedge clk);
        ack_man = 1'b0;
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 16'h0100) begin errors++; $display("FAIL rw_first_pc: got %b/%h expected 1/0100", inst_valid, inst_pc); end
        checks++; if (inst_data !== 16'h5B00) begin errors++; $display("FAIL rw_first_data: got %h expected 5b00", inst_data); end
    endtask

    task automatic test_redirect_ack();
        ack_auto = 1'b1; inst_ready = 1'b0;
        do_reset();
        repeat (5) @(negedge clk);
        checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b1) begin errors++; $display("FAIL ra_full: got req %b valid %b expected 0/1", imem_req, inst_valid); end
        // Full FIFO, pop, redirect, and a spurious ack while no request is up.
        inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0200;
        ack_auto = 1'b0; ack_man = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL ra_flush: got %b expected 0", inst_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0200) begin errors++; $display("FAIL ra_newreq: got %b/%h expected 1/0200", imem_req, imem_addr); end
        @(negedge clk);
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 16'h0200) begin errors++; $display("FAIL ra_first: got %b/%h expected 1/0200", inst_valid, inst_pc); end
        // Redirect coinciding with an ack and a pop.
        redirect_valid = 1'b1; redirect_pc = 16'h0300;
        @(negedge clk);
        redirect_valid = 1'b0;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL ra_ack_drop: got %b expected 0", inst_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0300) begin errors++; $display("FAIL ra_ack_addr: got %b/%h expected 1/0300", imem_req, imem_addr); end
        @(negedge clk);
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 16'h0300) begin errors++; $display("FAIL ra_ack_pc: got %b/%h expected 1/0300", inst_valid, inst_pc); end
        ack_man = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        @(negedge clk);
        checks++; if (w_req !== 1'b1 || w_addr !== 16'hFFFC) begin errors++; $display("FAIL wrap_addr0: got %b/%h expected 1/fffc", w_req, w_addr); end
        @(negedge clk);
        checks++; if (w_addr !== 16'h0000 || w_pc !== 16'hFFFC || w_valid !== 1'b1) begin errors++; $display("FAIL wrap_step1: got addr %h pc %h valid %b expected 0000/fffc/1", w_addr, w_pc, w_valid); end
        @(negedge clk);
        checks++; if (w_pc !== 16'h0000 || w_addr !== 16'h0004) begin errors++; $display("FAIL wrap_step2: got pc %h addr %h expected 0000/0004", w_pc, w_addr); end
    endtask

    task automatic test_reset_mid();
        ack_auto = 1'b0; ack_man = 1'b0; inst_ready = 1'b0;
        do_reset();
        @(negedge clk);
        ack_man = 1'b1;
        @(negedge clk);
        ack_man = 1'b0;
        checks++; if (inst_valid !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 16'h0004) begin errors++; $display("FAIL rm_pre: got valid %b req %b addr %h expected 1/1/0004", inst_valid, imem_req, imem_addr); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL rm_reset: got req %b valid %b expected 0/0", imem_req, inst_valid); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("FAIL rm_restart: got %b/%h expected 1/0000", imem_req, imem_addr); end
    endtask

    initial begin
        ack_auto = 1'b1; ack_man = 1'b0; inst_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = 16'h0000;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_wait();
        test_redirect_ack();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
